// File: rtl/quad_pkg.sv
// Shared types and Gray-code decode helpers for the quadrature step decoder.
// Step direction follows the up sequence 00->10->11->01->00.
package quad_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } qd_state_t;

    localparam logic [1:0] QD_S00 = 2'b00;
    localparam logic [1:0] QD_S10 = 2'b10;
    localparam logic [1:0] QD_S11 = 2'b11;
    localparam logic [1:0] QD_S01 = 2'b01;

    typedef struct packed {
        logic legal;
        logic illegal;
        logic dir;
    } qd_dec_t;

    function automatic logic [1:0] qd_next_up(input logic [1:0] s);
        logic [1:0] n;
        case (s)
            QD_S00:  n = QD_S10;
            QD_S10:  n = QD_S11;
            QD_S11:  n = QD_S01;
            default: n = QD_S00;
        endcase
        return n;
    endfunction

    function automatic qd_dec_t qd_dir(input logic [1:0] prev, input logic [1:0] cur);
        qd_dec_t    d;
        logic [1:0] diff;
        diff      = prev ^ cur;
        d.legal   = (diff == 2'b01) || (diff == 2'b10);
        d.illegal = (diff == 2'b11);
        d.dir     = (cur == qd_next_up(prev));
        return d;
    endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Per-channel synchroniser followed by a persistence filter; a new level is
// accepted once it has been seen on FILT_CYCLES consecutive synchronised cycles.
module quad_input_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_idle
);

    localparam logic [3:0] LP_LAST = 4'(FILT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [3:0]             r_cnt;
    logic                   r_level;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (w_s == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == LP_LAST) begin
            // the edge that would take the count to FILT_CYCLES commits the level
            r_level <= w_s;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_level = r_level;
    assign o_idle  = (r_cnt == '0) && (w_s == r_level);

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: filtered Gray-code tracking producing a step strobe,
// a direction level and a saturating count of illegal double transitions.
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 4,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             en,
    input  logic             clr_err,
    output logic             step,
    output logic             up,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [3:0] LP_INIT_WAIT = 4'(FILT_CYCLES);

    qd_state_t        r_state, w_state_nxt;
    logic [1:0]       r_s, r_prev, w_prev_nxt;
    logic [3:0]       r_init_cnt;
    logic             r_step, w_step_nxt;
    logic             r_up, w_up_nxt;
    logic             r_err, w_err_nxt;
    logic [ERR_W-1:0] r_err_cnt, w_err_cnt_nxt;
    logic             w_a_f, w_b_f, w_a_idle, w_b_idle;
    logic [1:0]       w_s;
    logic             w_init_done;
    qd_dec_t          w_dec;

    quad_input_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_CYCLES(FILT_CYCLES)
    ) u_filt_a (
        .clk    (clk),
        .reset  (reset),
        .i_raw  (a_in),
        .o_level(w_a_f),
        .o_idle (w_a_idle)
    );

    quad_input_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_CYCLES(FILT_CYCLES)
    ) u_filt_b (
        .clk    (clk),
        .reset  (reset),
        .i_raw  (b_in),
        .o_level(w_b_f),
        .o_idle (w_b_idle)
    );

    assign w_s         = {w_a_f, w_b_f};
    assign w_init_done = (r_init_cnt == LP_INIT_WAIT);
    assign w_dec       = qd_dir(r_prev, r_s);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= INIT;
            r_s        <= '0;
            r_prev     <= '0;
            r_init_cnt <= '0;
            r_step     <= 1'b0;
            r_up       <= 1'b1;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_s        <= w_s;
            r_prev     <= w_prev_nxt;
            r_init_cnt <= w_init_done ? r_init_cnt : r_init_cnt + 4'd1;
            r_step     <= w_step_nxt;
            r_up       <= w_up_nxt;
            r_err      <= w_err_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_prev_nxt    = r_prev;
        w_step_nxt    = 1'b0;
        w_up_nxt      = r_up;
        w_err_nxt     = 1'b0;
        w_err_cnt_nxt = r_err_cnt;
        case (r_state)
            INIT: begin
                // baseline taken from the live filter levels so r_s and r_prev agree on entry to TRACK
                w_prev_nxt = w_s;
                if (w_init_done && w_a_idle && w_b_idle) begin
                    w_state_nxt = TRACK;
                end
            end
            TRACK: begin
                w_prev_nxt = r_s;
                if (w_dec.legal) begin
                    w_step_nxt = en;
                    w_up_nxt   = w_dec.dir;
                end else if (w_dec.illegal) begin
                    w_err_nxt = en;
                    if (en && (r_err_cnt != '1)) begin
                        w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
                    end
                end
            end
            default: w_state_nxt = INIT;
        endcase
        if (clr_err) begin
            w_err_cnt_nxt = '0;
        end
    end

    assign step    = r_step;
    assign up      = r_up;
    assign err     = r_err;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: each pin change pushes its expected
// step/err event with due cycle; a negedge monitor pops and compares.
module tb_quad_step_decoder;

    localparam int unsigned LAT = 8;

    logic       clk;
    logic       reset;
    logic       a_in;
    logic       b_in;
    logic       en;
    logic       clr_err;
    logic       step;
    logic       up;
    logic       err;
    logic [7:0] err_cnt;

    typedef struct {
        int unsigned due;
        logic        step;
        logic        up;
        logic        err;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned seen_steps;
    int unsigned seen_errs;
    int unsigned exp_steps;
    int unsigned exp_errs;
    logic        m_up;
    logic [7:0]  m_cnt;

    quad_step_decoder #(
        .SYNC_STAGES(2),
        .FILT_CYCLES(4),
        .ERR_W(8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .a_in   (a_in),
        .b_in   (b_in),
        .en     (en),
        .clr_err(clr_err),
        .step   (step),
        .up     (up),
        .err    (err),
        .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                check_val("late", cyc, q[0].due);
                q.delete(0);
            end
            if (step || err) begin
                if (step) seen_steps++;
                if (err)  seen_errs++;
                if (q.size() == 0) begin
                    check_val("unexp_step", {31'd0, step}, 32'd0);
                    check_val("unexp_err", {31'd0, err}, 32'd0);
                end else begin
                    check_val("due", cyc, q[0].due);
                    check_val("step", {31'd0, step}, {31'd0, q[0].step});
                    check_val("up", {31'd0, up}, {31'd0, q[0].up});
                    check_val("err", {31'd0, err}, {31'd0, q[0].err});
                    check_val("err_cnt", {24'd0, err_cnt}, {24'd0, q[0].cnt});
                    q.delete(0);
                end
            end
        end
    end

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(posedge clk);
    endtask

    task automatic drive_pins(input logic a, input logic b);
        @(posedge clk);
        #1;
        a_in = a;
        b_in = b;
    endtask

    task automatic push_step(input logic dir);
        exp_t e;
        m_up   = dir;
        e.due  = cyc + LAT;
        e.step = 1'b1;
        e.up   = dir;
        e.err  = 1'b0;
        e.cnt  = m_cnt;
        q.push_back(e);
        exp_steps++;
    endtask

    task automatic push_err(input logic cleared);
        exp_t e;
        if (cleared)            m_cnt = 8'd0;
        else if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        e.due  = cyc + LAT;
        e.step = 1'b0;
        e.up   = m_up;
        e.err  = 1'b1;
        e.cnt  = m_cnt;
        q.push_back(e);
        exp_errs++;
    endtask

    task automatic step_to(input logic a, input logic b, input logic dir);
        drive_pins(a, b);
        push_step(dir);
        wait_cyc(10);
    endtask

    initial begin
        cyc        = 0;
        n_checks   = 0;
        n_errors   = 0;
        seen_steps = 0;
        seen_errs  = 0;
        exp_steps  = 0;
        exp_errs   = 0;
        m_up       = 1'b1;
        m_cnt      = 8'd0;
        reset      = 1'b1;
        a_in       = 1'b1;
        b_in       = 1'b1;
        en         = 1'b1;
        clr_err    = 1'b0;

        wait_cyc(3);
        @(negedge clk);
        check_val("rst_step", {31'd0, step}, 32'd0);
        check_val("rst_up", {31'd0, up}, 32'd1);
        check_val("rst_err", {31'd0, err}, 32'd0);
        check_val("rst_cnt", {24'd0, err_cnt}, 32'd0);

        // release with pins at 11: baseline only, no event
        @(posedge clk); #1; reset = 1'b0;
        wait_cyc(30);
        @(negedge clk);
        check_val("base11_steps", seen_steps, 32'd0);
        check_val("base11_errs", seen_errs, 32'd0);
        check_val("base11_up", {31'd0, up}, 32'd1);

        // reset mid-operation with new pin level 00
        @(posedge clk); #1; reset = 1'b1; a_in = 1'b0; b_in = 1'b0;
        wait_cyc(3);
        @(posedge clk); #1; reset = 1'b0;
        wait_cyc(20);
        @(negedge clk);
        check_val("base00_steps", seen_steps, 32'd0);

        // up sequence
        step_to(1'b1, 1'b0, 1'b1);
        step_to(1'b1, 1'b1, 1'b1);
        step_to(1'b0, 1'b1, 1'b1);
        step_to(1'b0, 1'b0, 1'b1);
        // down sequence then reversal
        step_to(1'b0, 1'b1, 1'b0);
        step_to(1'b1, 1'b1, 1'b0);
        step_to(1'b1, 1'b0, 1'b0);
        step_to(1'b0, 1'b0, 1'b0);
        step_to(1'b1, 1'b0, 1'b1);
        step_to(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_val("seq_steps", seen_steps, exp_steps);

        // glitch shorter than filter: ignored
        drive_pins(1'b1, 1'b0);
        wait_cyc(2);
        drive_pins(1'b0, 1'b0);
        wait_cyc(15);
        @(negedge clk);
        check_val("glitch3_steps", seen_steps, exp_steps);

        // pulse exactly filter length: up then down
        drive_pins(1'b1, 1'b0);
        push_step(1'b1);
        wait_cyc(3);
        drive_pins(1'b0, 1'b0);
        push_step(1'b0);
        wait_cyc(15);
        @(negedge clk);
        check_val("pulse4_steps", seen_steps, exp_steps);

        // illegal double transitions, saturating count
        for (int i = 0; i < 300; i++) begin
            drive_pins(i[0] ? 1'b0 : 1'b1, i[0] ? 1'b0 : 1'b1);
            push_err(1'b0);
            wait_cyc(10);
        end
        @(negedge clk);
        check_val("sat_cnt", {24'd0, err_cnt}, 32'd255);
        check_val("sat_errs", seen_errs, exp_errs);

        // clear coincident with an illegal event: clear wins, pulse still fires
        drive_pins(1'b1, 1'b1);
        push_err(1'b1);
        wait_cyc(LAT - 1);
        #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        wait_cyc(5);
        @(negedge clk);
        check_val("clr_cnt", {24'd0, err_cnt}, 32'd0);

        // back to 00 with up=0
        step_to(1'b0, 1'b1, 1'b1);
        step_to(1'b0, 1'b0, 1'b1);
        step_to(1'b1, 1'b0, 1'b1);
        step_to(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_val("pre_en_up", {31'd0, up}, 32'd0);

        // disabled step updates direction silently
        @(posedge clk); #1 en = 1'b0;
        drive_pins(1'b1, 1'b0);
        m_up = 1'b1;
        wait_cyc(12);
        @(negedge clk);
        check_val("en0_steps", seen_steps, exp_steps);
        check_val("en0_up", {31'd0, up}, 32'd1);
        @(posedge clk); #1 en = 1'b1;
        wait_cyc(10);
        @(negedge clk);
        check_val("reen_steps", seen_steps, exp_steps);
        step_to(1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        check_val("pending", q.size(), 32'd0);
        check_val("total_steps", seen_steps, exp_steps);
        check_val("total_errs", seen_errs, exp_errs);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Upstream stage for the 4-bit up/down counter.
- Converts a raw asynchronous quadrature encoder pair (A/B) into a one-cycle step strobe plus a direction level `up`. The counter's count enable is driven from `step` and its `up` input from `up`.
- Synchronises and glitch-filters both channels, decodes Gray-code transitions, and flags and counts illegal double transitions.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser; legal range 2..4.
- FILT_CYCLES, 4, consecutive synchronised cycles a new level must persist before it is accepted; legal range 1..15.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- a_in  in  1  encoder channel A, asynchronous to clk
- b_in  in  1  encoder channel B, asynchronous to clk
- en  in  1  step/error reporting enable
- clr_err  in  1  synchronous clear of err_cnt
- step  out  1  one-cycle pulse, one per accepted legal transition
- up  out  1  direction of the most recent legal step (1 = up)
- err  out  1  one-cycle pulse on an illegal transition
- err_cnt  out  ERR_W  saturating count of illegal transitions

Behaviour:
- Reset: asynchronous, active-high.
  - All synchroniser flops, filter counters and filtered levels reset to 0.
  - FSM resets to INIT.
  - Outputs reset to: step=0, up=1, err=0, err_cnt=0.
- Synchroniser: SYNC_STAGES flops per channel; the last-stage output is a_s / b_s.
- Filter, per channel:
  - Counter resets to 0 whenever a_s equals the filtered level a_f.
  - Counter increments while a_s differs from a_f.
  - When the counter reaches FILT_CYCLES, a_f takes a_s and the counter returns to 0.
  - A glitch shorter than FILT_CYCLES cycles never reaches a_f.
- Decode state: S = {a_f, b_f}, with previous value S_prev registered every cycle.
  - Up sequence: 00→10→11→01→00.
  - Down sequence: 00→01→11→10→00.
- FSM:
  - INIT: stays in INIT until both filter counters read 0 and FILT_CYCLES cycles have elapsed since reset release. Then S_prev is loaded with S without a step, and the FSM goes to TRACK. No step or err is ever issued in INIT.
  - TRACK:
    - S == S_prev: nothing happens.
    - S differs from S_prev in one bit: legal step. step=1 for exactly one cycle, and `up` is registered with the decoded direction on that same cycle.
    - S differs from S_prev in both bits: illegal. err=1 for one cycle, err_cnt increments, step=0, `up` is unchanged.
    - In every case S_prev takes S.
- Latency: a clean level change on one pin, stable before clock edge 0, produces step asserted after edge SYNC_STAGES+FILT_CYCLES+1. With default parameters this is 7 cycles.
- `up` holds its value between steps, so it is valid whenever step=1.
- en=0:
  - step and err are forced to 0, and err_cnt does not increment.
  - Filtering, S_prev tracking and `up` updates continue, so re-enabling produces no spurious step.
- err_cnt:
  - Saturates at 2^ERR_W−1 and stays there.
  - clr_err sets it to 0 on the next edge.
  - If clr_err and an illegal event occur in the same cycle, the result is 0 (clear wins); the err pulse still fires.
- Reset mid-operation: all state is discarded immediately. After reset release the block re-enters INIT and takes a new baseline; the pin level at that time never produces a step.
- Maximum step rate: one step per FILT_CYCLES+1 cycles per channel. Faster input is filtered out or flagged as err; it is never silently miscounted as a legal step.

Decomposition:
- Package quad_pkg holds:
  - enum qd_state_t {INIT, TRACK};
  - 2-bit Gray constants QD_S00, QD_S10, QD_S11, QD_S01;
  - function qd_dir(prev, cur) returning {legal, illegal, dir}.
- Sub-module quad_input_filter contains the synchroniser plus stability filter. It is parameterised by SYNC_STAGES and FILT_CYCLES, instantiated once per channel, and outputs the filtered level and a counter-idle flag.

Test Plan:
- Reset release with a_in=1, b_in=1 held → no step, no err; FSM in TRACK after FILT_CYCLES cycles; up=1.
- From baseline 00, apply the up sequence 10,11,01,00, holding each level 10 cycles (defaults) → 4 step pulses, each 7 cycles after its pin change; up=1 throughout.
- From 00 apply 01,11,10,00 → 4 step pulses with up=0; then apply 10 → step with up=1 (direction reversal).
- A pulse of 3 cycles on a_in with FILT_CYCLES=4 → no step, no err; a 4-cycle pulse → 2 steps (up then down).
- Change both pins 00→11 on the same cycle → err pulse, step=0, err_cnt=1. Repeat 300 times → err_cnt=255. Assert clr_err during an err event → err_cnt=0.
- With en=0, apply 00→10 → no step. Set en=1 with no further pin change → no step. Then apply 10→11 → one step with up=1.
